// File: rtl/wb_unit_if.sv
// Writeback unit bus bundle: decoder controls/operands, data-memory response and register-file write port.
interface wb_unit_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic               reg_we;
  logic [1:0]         reg_sel;
  logic [2:0]         load_sel;
  logic [RADDR_W-1:0] rd;
  logic [XLEN-1:0]    res;
  logic [XLEN-1:0]    pc_plus_4;
  logic [1:0]         addr_lo;
  logic               mem_rvalid;
  logic [XLEN-1:0]    mem_rdata;
  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]    rf_wdata;
  logic               stall;
  logic               mem_err;

  modport master (
    output in_valid, reg_we, reg_sel, load_sel, rd, res, pc_plus_4, addr_lo, mem_rvalid, mem_rdata,
    input  in_ready, rf_we, rf_waddr, rf_wdata, stall, mem_err
  );

  modport slave (
    input  in_valid, reg_we, reg_sel, load_sel, rd, res, pc_plus_4, addr_lo, mem_rvalid, mem_rdata,
    output in_ready, rf_we, rf_waddr, rf_wdata, stall, mem_err
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback execution unit: selects the register-file write value, waits for load data with a
// bounded timeout, and extracts/extends the loaded byte, half or word.
module wb_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      rst_n,
  wb_unit_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] REG_PC_PLUS_4 = 2'b01;
  localparam logic [1:0] REG_MEM       = 2'b10;

  localparam logic [2:0] LOAD_B  = 3'b000;
  localparam logic [2:0] LOAD_H  = 3'b001;
  localparam logic [2:0] LOAD_BU = 3'b100;
  localparam logic [2:0] LOAD_HU = 3'b101;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]         ld_sel_q, ld_sel_d;
  logic [1:0]         ld_lo_q, ld_lo_d;
  logic               rf_we_q, rf_we_d;
  logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
  logic               mem_err_q, mem_err_d;

  // Lane select plus sign/zero extension; unknown encodings fall back to a full word.
  function automatic logic [XLEN-1:0] extract(input logic [2:0] sel, input logic [1:0] lo,
                                              input logic [XLEN-1:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    h = lo[1] ? w[31:16] : w[15:0];
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (sel)
      LOAD_B:  extract = {{(XLEN-8){b[7]}}, b};
      LOAD_BU: extract = {{(XLEN-8){1'b0}}, b};
      LOAD_H:  extract = {{(XLEN-16){h[15]}}, h};
      LOAD_HU: extract = {{(XLEN-16){1'b0}}, h};
      default: extract = w;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ld_rd_q    <= '0;
      ld_sel_q   <= '0;
      ld_lo_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_rd_q    <= ld_rd_d;
      ld_sel_q   <= ld_sel_d;
      ld_lo_q    <= ld_lo_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Write port and x0 suppression: index/data only move on a real write.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_rd_d    = ld_rd_q;
    ld_sel_d   = ld_sel_q;
    ld_lo_d    = ld_lo_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    mem_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.reg_we) begin
          if (bus.reg_sel == REG_MEM) begin
            ld_rd_d  = bus.rd;
            ld_sel_d = bus.load_sel;
            ld_lo_d  = bus.addr_lo;
            cnt_d    = '0;
            state_d  = WAIT_MEM;
          end else if (bus.rd != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.rd;
            rf_wdata_d = (bus.reg_sel == REG_PC_PLUS_4) ? bus.pc_plus_4 : bus.res;
          end
        end
      end
      WAIT_MEM: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response arriving on the last allowed cycle still beats the timeout.
        if (bus.mem_rvalid) begin
          state_d = IDLE;
          if (ld_rd_q != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ld_rd_q;
            rf_wdata_d = extract(ld_sel_q, ld_lo_q, bus.mem_rdata);
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.stall    = (state_q == WAIT_MEM);
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.mem_err  = mem_err_q;
endmodule
